// File: rtl/uart_rx_pkg.sv
// Shared register map, STATUS bit positions and receiver FSM states for uart_rx.
// No logic of its own.
package uart_rx_pkg;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;

    localparam int ST_NOT_EMPTY  = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERRUN    = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_PARITY_ERR = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: registered pointers, head data is combinational from storage.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push while full is accepted only together with a pop; otherwise dropped.
module uart_rx_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign rdata_o   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with byte FIFO, sticky error flags and level irq (UART_RX_PARITY_EN adds even parity).
// Latency: bus response one cycle after req; byte pushed at mid-stop-bit plus 2-flop sync delay; irq one cycle later.
// Backpressure: none on the bus; a byte arriving at a full FIFO without a same-cycle pop is dropped and flags overrun.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int FifoDepth      = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    input  logic        uart_rx_i,
    output logic        rx_irq_o
);

    localparam int ClkPerBit = ClockFrequency / BaudRate;
    localparam int CntW      = $clog2(ClkPerBit);
    localparam logic [CntW-1:0] CntHalf = CntW'(ClkPerBit / 2);
    localparam logic [CntW-1:0] CntLast = CntW'(ClkPerBit - 1);

    logic [1:0]      r_sync;
    logic            w_rx;
    logic            r_rx_prev;
    rx_state_e       r_state;
    rx_state_e       w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            w_cnt_clr;
    logic            w_shift_en;
    logic            w_push;
    logic            w_frame_err_set;

    logic            w_pop;
    logic [7:0]      w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_overrun_set;

    logic [1:0]      w_addr;
    logic            w_rd;
    logic            w_wr;
    logic [4:2]      w_clr;
    logic [4:0]      w_status;
    logic [31:0]     w_rdata_mux;
    logic            w_par_err;
    logic            w_unused;

    logic            r_overrun;
    logic            r_frame_err;
    logic [1:0]      r_irq_en;
    logic            r_irq;
    logic            r_rvalid;
    logic [31:0]     r_rdata;

`ifdef UART_RX_PARITY_EN
    logic            w_par_sample;
    logic            r_par_bad;
    logic            r_par_err;
`endif

    assign w_rx = r_sync[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // IDLE arms only on a high-to-low edge, so a held-low break yields a single frame error.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_clr       = 1'b0;
        w_shift_en      = 1'b0;
        w_push          = 1'b0;
        w_frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (r_rx_prev && !w_rx) w_state_nxt = START;
            end
            START: begin
                if (r_cnt == CntHalf) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CntLast) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_cnt == CntLast) begin
                    w_cnt_clr    = 1'b1;
                    w_par_sample = 1'b1;
                    w_state_nxt  = STOP;
                end
            end
`endif
            STOP: begin
                if (r_cnt == CntLast) begin
                    w_cnt_clr       = 1'b1;
                    w_state_nxt     = IDLE;
                    w_frame_err_set = !w_rx;
`ifdef UART_RX_PARITY_EN
                    w_push          = w_rx && !r_par_bad;
`else
                    w_push          = w_rx;
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_sync    <= {r_sync[0], uart_rx_i};
            r_rx_prev <= w_rx;
            r_cnt     <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (w_shift_en) begin
                r_shift   <= {w_rx, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    uart_rx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .wdata_i (r_shift),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_addr        = device_addr_i[3:2];
    assign w_rd          = device_req_i && !device_we_i;
    assign w_wr          = device_req_i && device_we_i && device_be_i[0];
    assign w_pop         = w_rd && (w_addr == REG_RXDATA) && !w_empty;
    assign w_overrun_set = w_push && w_full && !w_pop;
    assign w_clr         = (w_wr && (w_addr == REG_STATUS)) ? device_wdata_i[4:2] : 3'b000;

`ifdef UART_RX_PARITY_EN
    assign w_par_err = r_par_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_par_bad <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            if (w_par_sample) r_par_bad <= ^{r_shift, w_rx};
            r_par_err <= (r_par_err && !w_clr[4]) || (w_par_sample && ^{r_shift, w_rx});
        end
    end
`else
    assign w_par_err = 1'b0;
`endif

    assign w_status[ST_NOT_EMPTY]  = !w_empty;
    assign w_status[ST_FULL]       = w_full;
    assign w_status[ST_OVERRUN]    = r_overrun;
    assign w_status[ST_FRAME_ERR]  = r_frame_err;
    assign w_status[ST_PARITY_ERR] = w_par_err;

    always_comb begin
        w_rdata_mux = '0;
        case (w_addr)
            REG_RXDATA: w_rdata_mux = {24'h0, w_empty ? 8'h00 : w_head};
            REG_STATUS: w_rdata_mux = {27'h0, w_status};
            REG_IRQ_EN: w_rdata_mux = {30'h0, r_irq_en};
            default:    w_rdata_mux = '0;
        endcase
    end

    // Set terms are OR-ed after the clear so a same-cycle event beats W1C.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq_en    <= 2'b00;
            r_irq       <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_overrun   <= (r_overrun && !w_clr[2]) || w_overrun_set;
            r_frame_err <= (r_frame_err && !w_clr[3]) || w_frame_err_set;
            if (w_wr && (w_addr == REG_IRQ_EN)) r_irq_en <= device_wdata_i[1:0];
            r_irq       <= (r_irq_en[0] && !w_empty) ||
                           (r_irq_en[1] && (r_overrun || r_frame_err || w_par_err));
            r_rvalid    <= device_req_i;
            r_rdata     <= w_rd ? w_rdata_mux : '0;
        end
    end

    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign rx_irq_o        = r_irq;

    assign w_unused = ^{device_addr_i, device_be_i, device_wdata_i, w_clr};

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames against a queue-based model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115_200;
    localparam int DEPTH  = 8;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be    = '0;
    logic        line  = 1'b1;
    logic        rvalid;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int irq_rise;

    logic [7:0] model_q[$];
    logic       m_ovr  = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_perr = 1'b0;
    logic [1:0] m_en   = 2'b00;

    uart_rx #(
        .ClockFrequency (CLK_HZ),
        .BaudRate       (BAUD),
        .FifoDepth      (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .device_req_i    (req),
        .device_addr_i   (addr),
        .device_we_i     (we),
        .device_be_i     (be),
        .device_wdata_i  (wdata),
        .device_rvalid_o (rvalid),
        .device_rdata_o  (rdata),
        .uart_rx_i       (line),
        .rx_irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: a good frame enqueues (or flags overrun when DEPTH bytes are held), a bad frame only flags.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
        if (!par_ok)  m_perr = 1'b1;
        if (!stop_ok) m_ferr = 1'b1;
        if (stop_ok && par_ok) begin
            if (model_q.size() == DEPTH) m_ovr = 1'b1;
            else                         model_q.push_back(b);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {27'h0, m_perr, m_ferr, m_ovr, (model_q.size() == DEPTH), (model_q.size() != 0)};
    endfunction

    function automatic logic [31:0] model_pop();
        if (model_q.size() == 0) return 32'h0;
        return {24'h0, model_q.pop_front()};
    endfunction

    function automatic logic exp_irq();
        return (m_en[0] && model_q.size() != 0) || (m_en[1] && (m_ovr || m_ferr || m_perr));
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
        return {stop_bit, ^b, b, 1'b0};
`else
        return {1'b1, stop_bit, b, 1'b0};
`endif
    endfunction

    // Drives one frame LSB first, recording the first cycle (from start-bit edge) that irq is seen high.
    task automatic send_frame(input logic [10:0] bits);
        int cyc;
        cyc = 0;
        irq_rise = -1;
        for (int i = 0; i < NBITS; i++) begin
            line = bits[i];
            repeat (CPB) begin
                @(negedge clk);
                cyc++;
                if (irq && irq_rise < 0) irq_rise = cyc;
            end
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        check("rd_rvalid", {31'h0, rvalid}, 32'h1);
        d = rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] bev);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = dat; be = bev;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check("wr_rvalid", {31'h0, rvalid}, 32'h1);
        check("wr_rdata", rdata, 32'h0);
    endtask

    initial begin : main
        logic [31:0] d;
        logic [7:0]  b;
        logic        ok;
        int          lo;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(32'h4, d); check("rst_status", d, 32'h0);
        bus_read(32'h8, d); check("rst_irq_en", d, 32'h0);

        // Single byte
        send_frame(mk_frame(8'hA5, 1'b1));
        model_frame(8'hA5, 1'b1, 1'b1);
        bus_read(32'h4, d); check("a5_status", d, exp_status());
        bus_read(32'h0, d); check("a5_rxdata", d, model_pop());
        bus_read(32'h4, d); check("a5_status_after", d, exp_status());
        bus_read(32'h0, d); check("empty_rxdata", d, model_pop());
        bus_read(32'hC, d); check("reg_c", d, 32'h0);

        // Overflow: nine bytes into eight entries
        for (int i = 0; i < 9; i++) begin
            send_frame(mk_frame(8'(i), 1'b1));
            model_frame(8'(i), 1'b1, 1'b1);
        end
        bus_read(32'h4, d); check("ovf_status", d, exp_status());
        for (int i = 0; i < 8; i++) begin
            bus_read(32'h0, d); check("ovf_rxdata", d, model_pop());
        end
        bus_read(32'h4, d); check("ovf_status_drained", d, exp_status());
        bus_write(32'h4, 32'h4, 4'hF); m_ovr = 1'b0;
        bus_read(32'h4, d); check("ovf_w1c", d, exp_status());

        // Stop bit 0 followed by a long break: exactly one frame error
        send_frame(mk_frame(8'h00, 1'b0));
        model_frame(8'h00, 1'b0, 1'b1);
        bus_read(32'h4, d); check("ferr_status", d, exp_status());
        bus_write(32'h4, 32'h8, 4'hF); m_ferr = 1'b0;
        repeat (11 * CPB) @(negedge clk);
        line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        bus_read(32'h4, d); check("break_status", d, exp_status());

        // Short low glitch on idle line
        line = 1'b0;
        repeat (100) @(negedge clk);
        line = 1'b1;
        repeat (CPB) @(negedge clk);
        bus_read(32'h4, d); check("glitch_status", d, exp_status());
        bus_read(32'h0, d); check("glitch_rxdata", d, model_pop());

        // Byte-enable gating, then rx-available interrupt
        bus_write(32'h8, 32'h3, 4'hE);
        bus_read(32'h8, d); check("be_gate", d, {30'h0, m_en});
        bus_write(32'h8, 32'h1, 4'hF); m_en = 2'b01;
        repeat (2) @(negedge clk);
        check("irq_idle", {31'h0, irq}, {31'h0, exp_irq()});
        send_frame(mk_frame(8'h3C, 1'b1));
        model_frame(8'h3C, 1'b1, 1'b1);
        lo = (NBITS - 1) * CPB + CPB / 2;
        check("irq_rise_window", {31'h0, (irq_rise >= lo && irq_rise <= lo + 8)}, 32'h1);
        bus_read(32'h0, d); check("irq_rxdata", d, model_pop());
        check("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("irq_drop", {31'h0, irq}, 32'h0);

`ifdef UART_RX_PARITY_EN
        send_frame({1'b1, 1'b0, 8'h01, 1'b0});
        model_frame(8'h01, 1'b1, 1'b0);
        bus_read(32'h4, d); check("par_bad_status", d, exp_status());
        bus_write(32'h4, 32'h10, 4'hF); m_perr = 1'b0;
        send_frame({1'b1, 1'b1, 8'h01, 1'b0});
        model_frame(8'h01, 1'b1, 1'b1);
        bus_read(32'h4, d); check("par_ok_status", d, exp_status());
        bus_read(32'h0, d); check("par_ok_rxdata", d, model_pop());
`endif

        // Randomized frames, irq enables and reads
        m_en = 2'($urandom_range(0, 3));
        bus_write(32'h8, {30'h0, m_en}, 4'hF);
        for (int k = 0; k < 2; k++) begin
            b  = 8'($urandom);
            ok = (k == 0) || ($urandom_range(0, 2) != 0);
            send_frame(mk_frame(b, ok));
            model_frame(b, ok, 1'b1);
            line = 1'b1;
            repeat (4) @(negedge clk);
            check("rnd_irq", {31'h0, irq}, {31'h0, exp_irq()});
            bus_read(32'h4, d); check("rnd_status", d, exp_status());
            if (model_q.size() > 1 && $urandom_range(0, 1) == 1) begin
                bus_read(32'h0, d); check("rnd_rxdata", d, model_pop());
            end
        end

        // Reset mid-frame with data still queued
        line = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        line = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_en = 2'b00;
        repeat (2) @(negedge clk);
        bus_read(32'h4, d); check("midrst_status", d, exp_status());
        bus_read(32'h0, d); check("midrst_rxdata", d, model_pop());
        bus_read(32'h8, d); check("midrst_irq_en", d, {30'h0, m_en});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Memory-mapped UART receiver peripheral that sits on the system bus as a device, alongside the existing UART transmitter.
- Oversamples the asynchronous uart_rx_i line and deframes 8N1 characters.
- Buffers received bytes in a small FIFO.
- Exposes data and status registers to the core's data port.
- Raises a level interrupt for the core's fast-interrupt inputs.

Parameters:
- ClockFrequency, 50_000_000, system clock in Hz.
- BaudRate, 115_200, line rate in bit/s; ClkPerBit = ClockFrequency/BaudRate (integer divide; 434 at defaults).
- FifoDepth, 8, receive FIFO entries; must be a power of two, at least 2.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- device_req_i  input  1  bus request (always accepted; the bus generates the grant).
- device_addr_i  input  32  byte address; only bits [3:2] are decoded.
- device_we_i  input  1  write enable.
- device_be_i  input  4  byte enables; writes act only if be[0] is set.
- device_wdata_i  input  32  write data.
- device_rvalid_o  output  1  response valid, exactly one cycle after each req (reads and writes).
- device_rdata_o  output  32  read data, valid with rvalid; 0 for writes.
- uart_rx_i  input  1  serial line, idle high, asynchronous.
- rx_irq_o  output  1  level interrupt, registered.

Behaviour:
- Reset values: device_rvalid_o=0, device_rdata_o=0, rx_irq_o=0. FIFO empty, sticky flags 0, irq enables 0, FSM in IDLE. Synchroniser flops reset to 1.
- Input path: uart_rx_i passes through a 2-flop synchroniser. Everything below uses the synchronised value.
- FSM:
  - IDLE: a high-to-low transition -> START, counter=0.
  - START: at count ClkPerBit/2, sample the line. If 0 -> DATA, counter reset, bit index 0. If 1 -> IDLE (glitch, nothing recorded).
  - DATA: at count ClkPerBit-1, sample the bit, LSB first, into a shift register. After bit 7 -> STOP.
  - STOP: at count ClkPerBit-1, sample the stop bit.
    - Stop=1: push the byte.
    - Stop=0: set frame_err and discard the byte.
    - Either way -> IDLE.
  - IDLE waits for the line to be high before it re-arms, so a held-low line (break) produces exactly one frame error.
- Register map (word offsets):
  - 0x0 RXDATA (read): [7:0] = FIFO head; the read pops the entry. Reading when empty returns 0 with no pointer change. Writes are ignored.
  - 0x4 STATUS (read): [0] not_empty, [1] full, [2] overrun, [3] frame_err, [4] parity_err (optional feature), others 0. Write: write-1-to-clear on bits [4:2].
  - 0x8 IRQ_EN (read/write): [0] rx-available enable, [1] error enable.
  - 0xC reads 0; writes ignored.
- Push to a full FIFO with no pop in the same cycle: byte dropped, overrun set.
- Push and pop in the same cycle: both take effect, including when full; no overrun.
- Sticky flag set and W1C clear in the same cycle: the set wins.
- FIFO pointers are log2(FifoDepth)+1 bits wide and wrap naturally. Empty is pointers equal; full is MSBs differing with the lower bits equal.
- rx_irq_o is registered: next = (en[0] & not_empty) | (en[1] & (overrun | frame_err | parity_err)). It updates one cycle after the condition changes.
- device_rdata_o reflects register state at the request cycle, before that cycle's update.
- Reset asserted mid-frame: the frame is aborted, the FSM returns to IDLE and FIFO contents are lost.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit is sampled after bit 7 (state PARITY, one bit period) before STOP.
  - Parity mismatch sets parity_err (STATUS[4]) and discards the byte. A stop-bit error is still checked.
- Undefined: 8N1 only, no PARITY state, STATUS[4] reads 0 and W1C on it has no effect.

Decomposition:
- uart_rx_pkg holds:
  - register word offsets: RXDATA=0, STATUS=1, IRQ_EN=2;
  - STATUS bit indices;
  - the rx_state_e enum: IDLE, START, DATA, PARITY, STOP.
- Sub-module uart_rx_fifo: synchronous FIFO with push/pop/full/empty and head data, parameterised by Depth and Width=8, same clk_i/rst_ni.

Test Plan:
- Send 0xA5 at 115200 (434 clk/bit) -> STATUS=0x1; RXDATA read returns 0xA5; STATUS then reads 0x0.
- Send 9 bytes 0x00..0x08 without reading -> STATUS=0x7 (not_empty, full, overrun); 8 reads return 0x00..0x07; W1C 0x4 clears overrun.
- Send a frame with stop bit 0 -> FIFO empty, STATUS=0x8; a held-low line produces only one frame_err.
- Low glitch of 100 clk on idle line -> FSM returns to IDLE, STATUS=0x0, FIFO empty.
- IRQ_EN=0x1, receive 0x3C -> rx_irq_o rises within 2 cycles of push; reading RXDATA drops it the cycle after the pop.
- With UART_RX_PARITY_EN, send 0x01 with parity bit 0 -> byte discarded, STATUS=0x10; with parity 1 -> 0x01 accepted.
